mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is `clk` and is rising-edge; the reset is `rst_n`, asynchronous and active-low.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- ex_valid  in  1  execute result present.
- ex_alu_out  in  32  ALU result (memory address or writeback value).
- ex_store_data  in  32  store operand.
- ex_rd  in  5  destination register.
- ex_reg_wr  in  1  instruction writes rd.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- ex_unsigned  in  1  zero-extend loads.
- stall  out  1  ex_* not accepted this cycle.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  write data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- wb_valid  out  1  writeback pulse.
- wb_we  out  1  register write enable.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- misalign  out  1  misaligned-access pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ and WAIT; `stall` SHALL equal (state != IDLE), and the ex_* inputs SHALL be sampled only in IDLE.
REQ-004 In IDLE, ex_valid with neither ex_mem_rd nor ex_mem_wr set SHALL produce, at the next edge, a one-cycle wb_valid with wb_we=ex_reg_wr, wb_rd=ex_rd and wb_data=ex_alu_out, giving latency 1.
REQ-005 In IDLE, ex_valid with a memory operation SHALL capture address, data, size, rd and flags, then move to REQ; if ex_mem_rd and ex_mem_wr are both set, the operation SHALL be treated as a store.
REQ-006 In REQ, dmem_req SHALL be 1 and dmem_addr/we/wdata/be SHALL stay stable until dmem_gnt is sampled high.
REQ-007 When dmem_gnt is sampled high for a store, the FSM SHALL return to IDLE and pulse wb_valid with wb_we=0.
REQ-008 When dmem_gnt is sampled high for a load, the FSM SHALL move to WAIT.
REQ-009 In WAIT, when dmem_rvalid is sampled high, the FSM SHALL pulse wb_valid with wb_we=captured reg_wr and the aligned load data, then return to IDLE.
REQ-010 dmem_rvalid SHALL be ignored in IDLE and REQ, and dmem_gnt SHALL be ignored outside REQ.
REQ-011 dmem_addr SHALL equal {addr[31:2],2'b00}, with off=addr[1:0].
REQ-012 Stores SHALL drive dmem_wdata and dmem_be as follows:
- byte: wdata = store_data[7:0] replicated x4, be = 4'b0001<<off.
- half: wdata = store_data[15:0] replicated x2, be = 4'b0011<<(2*off[1]).
- word: wdata = store_data, be = 4'b1111.
REQ-013 Loads SHALL select the byte at off or the half at off[1], then sign-extend, or zero-extend when captured unsigned=1.
REQ-014 dmem_req, dmem_we, wb_valid and misalign SHALL be single registered pulses or levels as stated above, with no combinational path from dmem_* inputs to dmem_* outputs.

Reset
REQ-015 rst_n low SHALL force state=IDLE and set stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_we, wb_rd, wb_data and misalign to 0.
REQ-016 Asserting reset in REQ or WAIT SHALL abandon the access with no wb_valid, and a late dmem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-017 With MEM_WB_MISALIGN_TRAP_EN defined, a half access with off[0]=1, or a word access with off!=0, SHALL issue no dmem_req, SHALL stay in IDLE, and SHALL pulse misalign and wb_valid (wb_we=0) at the next edge.
REQ-018 Without MEM_WB_MISALIGN_TRAP_EN, misalign SHALL be tied to 0, half accesses SHALL ignore off[0], and word accesses SHALL ignore off.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ALU op: ex_alu_out=0x1234, rd=5, reg_wr=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, stall stays 0.
- Store byte: addr=0x103, data=0xAB, gnt after 2 cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB, req held 3 cycles, then wb_valid with wb_we=0.
- Load half signed: addr=0x202, rdata=0x8001_0000, gnt immediate, rvalid 3 cycles later -> wb_data=0xFFFF8001; unsigned -> 0x00008001.
- Reset in WAIT, then rvalid pulsed after release -> no wb_valid, state IDLE, stall=0.
- Word load at addr=0x301: with MEM_WB_MISALIGN_TRAP_EN -> misalign=1, no dmem_req; without -> dmem_addr=0x300, full word returned.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : Memory / writeback pipeline stage. ALU results pass straight to
//            writeback; loads and stores run a request/grant/rvalid handshake
//            against the data memory, with byte/half/word lane steering and
//            sign/zero extension of load data.
// Options  : MEM_WB_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses are trapped (misalign pulse, no memory request). When
//            undefined, low address bits are ignored for half/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  // execute stage
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  output logic        stall,
  // data memory
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  // writeback
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state;

  // Operation context captured when a memory access is accepted.
  logic [1:0]  cap_off;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic        cap_reg_wr;
  logic [4:0]  cap_rd;
  logic        cap_is_store;

  // Decode of the incoming execute-stage operation.
  logic [1:0]  ex_off;
  logic        ex_is_mem;
  logic        ex_misaligned;
  logic        ex_accept_mem;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  // Load data after lane selection and extension.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ex_off    = ex_alu_out[1:0];
  // A store with the load flag also set is still a store: mem_wr dominates.
  assign ex_is_mem = ex_mem_rd | ex_mem_wr;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  assign ex_misaligned = ((ex_size == SIZE_HALF) && ex_off[0]) ||
                         (ex_size[1] && (ex_off != 2'b00));
`else
  assign ex_misaligned = 1'b0;
`endif

  // Memory accesses that actually go out on the dmem port this cycle.
  assign ex_accept_mem = (state == ST_IDLE) && ex_valid && ex_is_mem && !ex_misaligned;

  assign stall = (state != ST_IDLE);

  // Steer store data onto the byte lanes it targets and build the enables.
  always_comb begin
    lane_wdata = ex_store_data;
    lane_be    = 4'b1111;
    case (ex_size)
      SIZE_BYTE: begin
        lane_wdata = {4{ex_store_data[7:0]}};
        lane_be    = 4'b0001 << ex_off;
      end
      SIZE_HALF: begin
        lane_wdata = {2{ex_store_data[15:0]}};
        lane_be    = ex_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = ex_store_data;
        lane_be    = 4'b1111;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    case (cap_off)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    // Half selection only looks at off[1]; off[0] is either trapped or ignored.
    ld_half = cap_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_size)
      SIZE_BYTE: ld_data = {{24{~cap_unsigned & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{~cap_unsigned & ld_half[15]}}, ld_half};
      default:   ld_data = dmem_rdata;
    endcase
  end

  // Hold the access context for the duration of the memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_off      <= 2'b00;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_reg_wr   <= 1'b0;
      cap_rd       <= 5'd0;
      cap_is_store <= 1'b0;
    end else if (ex_accept_mem) begin
      cap_off      <= ex_off;
      cap_size     <= ex_size;
      cap_unsigned <= ex_unsigned;
      cap_reg_wr   <= ex_reg_wr;
      cap_rd       <= ex_rd;
      cap_is_store <= ex_mem_wr;
    end
  end

  // Stage FSM with all dmem/writeback outputs registered (no input->output paths).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'h0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0;
      misalign   <= 1'b0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!ex_is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= ex_reg_wr;
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_out;
            end else if (ex_misaligned) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= ex_rd;
              misalign <= 1'b1;
            end else begin
              // Address, data and enables are frozen here until the grant.
              dmem_req   <= 1'b1;
              dmem_we    <= ex_mem_wr;
              dmem_addr  <= {ex_alu_out[31:2], 2'b00};
              dmem_wdata <= lane_wdata;
              dmem_be    <= lane_be;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (cap_is_store) begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= cap_rd;
              state    <= ST_IDLE;
            end else begin
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= cap_reg_wr;
            wb_rd    <= cap_rd;
            wb_data  <= ld_data;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Scoreboard bench for mem_wb_stage. A driver issues directed and
//            random operations and pushes the expected memory requests and
//            writebacks; a memory responder and a writeback monitor pop and
//            compare. Follows MEM_WB_MISALIGN_TRAP_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_unsigned;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_size;
  logic        stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Responder-driven vs. manually driven memory inputs.
  bit          auto_mode;
  logic        r_gnt, r_rvalid, m_gnt, m_rvalid;
  logic [31:0] r_rdata, m_rdata;
  assign dmem_gnt    = auto_mode ? r_gnt    : m_gnt;
  assign dmem_rvalid = auto_mode ? r_rvalid : m_rvalid;
  assign dmem_rdata  = auto_mode ? r_rdata  : m_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          check_rd;
    logic        mis;
    int          at_cyc;
  } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (arithmetic view of the rules) ----------
  function automatic bit model_mis(input logic [1:0] sz, input logic [1:0] off);
    if (!TRAP) return 1'b0;
    if (sz == 2'd1) return (off % 2) == 1;
    if (sz >= 2'd2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
    int          sh, w;
    logic [31:0] mask, v;
    if (sz == 2'd0) begin sh = 8 * off; w = 8; end
    else if (sz == 2'd1) begin sh = 16 * (off / 2); w = 16; end
    else return word;
    mask = (32'h1 << w) - 32'h1;
    v    = (word >> sh) & mask;
    if (!uns && v[w-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  // kind: 0 ALU, 1 load, 2 store, 3 load+store flags (a store)
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw, input logic [1:0] sz,
                       input logic uns, input int gd, input int rvd, input logic [31:0] rdat);
    int   waited = 0;
    bit   mis;
    req_t q;
    wb_t  e;
    while (stall !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (stall !== 1'b0) begin
      chk("issue_stall_timeout", stall, 32'h0);
      return;
    end
    ex_valid = 1'b1; ex_alu_out = a; ex_store_data = d; ex_rd = rd; ex_reg_wr = rw;
    ex_mem_rd = (kind == 1 || kind == 3); ex_mem_wr = (kind >= 2);
    ex_size = sz; ex_unsigned = uns;
    mis = (kind != 0) && model_mis(sz, a[1:0]);
    e.rd = rd; e.data = 32'h0; e.check_rd = 1'b0; e.mis = 1'b0; e.at_cyc = -1; e.we = 1'b0;
    if (kind == 0) begin
      e.we = rw; e.data = a; e.check_rd = 1'b1; e.at_cyc = cyc + 1;
    end else if (mis) begin
      e.mis = 1'b1; e.at_cyc = cyc + 1;
    end else begin
      q.addr = a & ~32'h3; q.we = (kind >= 2); q.wdata = model_wdata(sz, d);
      q.be = model_be(sz, a[1:0]); q.gnt_dly = gd; q.rv_dly = rvd; q.rdata = rdat;
      exp_req.push_back(q);
      if (kind == 1) begin
        e.we = rw; e.data = model_load(rdat, sz, a[1:0], uns); e.check_rd = 1'b1;
      end
    end
    exp_wb.push_back(e);
    @(negedge clk);
    ex_valid = 1'b0;
    if (kind == 0 || mis) chk("stall_after_issue", stall, 32'h0);
    else                  chk("stall_after_issue", stall, 32'h1);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int          phase = 0, cnt = 0, held = 0;
    req_t        cur;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    r_gnt = 1'b0; r_rvalid = 1'b0; r_rdata = 32'h0;
    cur.we = 1'b1; cur.gnt_dly = 0; cur.rv_dly = 0; cur.rdata = 32'h0;
    forever begin
      @(negedge clk);
      r_gnt = 1'b0; r_rvalid = 1'b0;
      if (!auto_mode || !rst_n) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (dmem_req === 1'b1) begin
              if (exp_req.size() == 0) begin
                chk("unexpected_req", dmem_req, 32'h0);
                cur.we = dmem_we; cur.gnt_dly = 0; cur.rv_dly = 0; cur.rdata = 32'h0;
              end else begin
                cur = exp_req.pop_front();
                chk("dmem_addr", dmem_addr, cur.addr);
                chk("dmem_we", dmem_we, cur.we);
                if (cur.we) begin
                  chk("dmem_wdata", dmem_wdata, cur.wdata);
                  chk("dmem_be", dmem_be, cur.be);
                end
              end
              c_addr = dmem_addr; c_we = dmem_we; c_wdata = dmem_wdata; c_be = dmem_be;
              held = 1; cnt = cur.gnt_dly;
              if (cnt == 0) begin r_gnt = 1'b1; phase = 2; end
              else begin cnt--; phase = 1; r_rvalid = ($urandom_range(0, 3) == 0); r_rdata = $urandom; end
            end else begin
              // Stray handshakes while nothing is outstanding must be ignored.
              r_gnt = ($urandom_range(0, 7) == 0);
              r_rvalid = ($urandom_range(0, 7) == 0);
              r_rdata = $urandom;
            end
          end
          1: begin
            chk("req_held", dmem_req, 32'h1);
            chk("addr_stable", dmem_addr, c_addr);
            chk("we_stable", dmem_we, c_we);
            chk("wdata_stable", dmem_wdata, c_wdata);
            chk("be_stable", dmem_be, c_be);
            held++;
            if (cnt == 0) begin r_gnt = 1'b1; phase = 2; end
            else begin cnt--; r_rvalid = ($urandom_range(0, 3) == 0); r_rdata = $urandom; end
          end
          2: begin
            chk("req_drop", dmem_req, 32'h0);
            chk("req_cycles", 32'(held), 32'(cur.gnt_dly + 1));
            if (cur.we) phase = 0;
            else begin
              cnt = cur.rv_dly;
              if (cnt == 0) begin r_rvalid = 1'b1; r_rdata = cur.rdata; phase = 4; end
              else begin cnt--; phase = 3; r_gnt = ($urandom_range(0, 3) == 0); r_rdata = $urandom; end
            end
          end
          3: begin
            if (cnt == 0) begin r_rvalid = 1'b1; r_rdata = cur.rdata; phase = 4; end
            else begin cnt--; r_gnt = ($urandom_range(0, 3) == 0); r_rdata = $urandom; end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // ---------------- writeback monitor ----------------
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
        if (exp_wb.size() == 0) begin
          chk("unexpected_wb", wb_valid, 32'h0);
        end else begin
          e = exp_wb.pop_front();
          chk("wb_we", wb_we, e.we);
          chk("wb_misalign", misalign, e.mis);
          if (e.check_rd) begin
            chk("wb_rd", wb_rd, e.rd);
            chk("wb_data", wb_data, e.data);
          end
          if (e.at_cyc >= 0) chk("wb_latency", 32'(cyc), 32'(e.at_cyc));
        end
      end else if (misalign === 1'b1) begin
        chk("stray_misalign", misalign, 32'h0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    rst_n = 1'b0; auto_mode = 1'b0;
    ex_valid = 1'b0; ex_alu_out = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
    ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 32'h0);
    chk("rst_dmem_req", dmem_req, 32'h0);
    chk("rst_dmem_we", dmem_we, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("rst_dmem_be", dmem_be, 32'h0);
    chk("rst_wb_valid", wb_valid, 32'h0);
    chk("rst_wb_we", wb_we, 32'h0);
    chk("rst_wb_rd", wb_rd, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_misalign", misalign, 32'h0);
    rst_n = 1'b1;
    auto_mode = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    issue(0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 2'd2, 1'b0, 0, 0, 32'h0);
    issue(2, 32'h0000_0103, 32'h0000_00AB, 5'd7, 1'b1, 2'd0, 1'b0, 2, 0, 32'h0);
    issue(1, 32'h0000_0202, 32'h0, 5'd9, 1'b1, 2'd1, 1'b0, 0, 3, 32'h8001_0000);
    issue(1, 32'h0000_0202, 32'h0, 5'd9, 1'b1, 2'd1, 1'b1, 0, 3, 32'h8001_0000);
    issue(1, 32'h0000_0301, 32'h0, 5'd11, 1'b1, 2'd2, 1'b0, 1, 1, 32'hCAFE_F00D);
    issue(3, 32'h0000_0400, 32'h1122_3344, 5'd12, 1'b1, 2'd2, 1'b0, 1, 0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      issue(int'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), $urandom);
    end

    // Drain outstanding work.
    waited = 0;
    while ((exp_wb.size() != 0 || exp_req.size() != 0 || stall !== 1'b0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_idle", stall, 32'h0);
    chk("drain_wb_left", 32'(exp_wb.size()), 32'h0);
    @(negedge clk);
    auto_mode = 1'b0;

    // Reset while waiting for load data; a late rvalid must be ignored.
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_out = 32'h0000_0400; ex_rd = 5'd3; ex_reg_wr = 1'b1;
    ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_size = 2'd2; ex_unsigned = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("wait_test_req", dmem_req, 32'h1);
    chk("wait_test_stall_req", stall, 32'h1);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    chk("wait_test_req_drop", dmem_req, 32'h0);
    chk("wait_test_stall_wait", stall, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", stall, 32'h0);
    chk("async_rst_wb_valid", wb_valid, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
    @(negedge clk);
    m_rvalid = 1'b0;
    chk("late_rvalid_wb", wb_valid, 32'h0);
    chk("late_rvalid_stall", stall, 32'h0);
    repeat (3) @(negedge clk);
    chk("post_reset_idle", stall, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case something hangs beyond every bounded wait.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
